stage5_writeback: RTL and testbench
===================================

STAGE5_WRITEBACK -- requirements
Module: stage5_writeback

Interface
REQ-001 Parameter: WIDTH, 32, datapath and register width.
REQ-002 Parameter: REGISTER_DEPTH, 32, architectural register count; address width clog2(REGISTER_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 axis_in.tvalid  in  1  retiring instruction present from memory stage.
REQ-006 axis_in.tready  out  1  stage can accept this cycle.
REQ-007 axis_in.tdata  in  struct  program_counter[WIDTH], opcode[7], rd[5], funct3[3], alu_result[WIDTH], load_data[WIDTH], byte_offset[2].
REQ-008 regport_write.enable / .address[5] / .data[WIDTH]  out  register-file write port.
REQ-009 regport_write_ready  in  1  register file accepts a write this cycle (arbitrated with debug port).
REQ-010 fwd_valid / fwd_rd[5] / fwd_data[WIDTH]  out  forwarding of pending write to decode/execute.
REQ-011 misaligned_load  out  1  one-cycle pulse on misaligned load retire attempt.
REQ-012 instret  out  64  retired-instruction counter.

Function
REQ-013 Single holding register (hold_valid, rd, data, write_flag); handshake on axis_in.tvalid && axis_in.tready.
REQ-014 axis_in.tready = !hold_valid || (regport_write_ready || !write_flag); combinational, no dependency on tvalid.
REQ-015 On accept, result formatted combinationally and captured; write presented the next cycle (latency 1).
REQ-016 Result select by opcode: OP_LOAD -> formatted load; OP_JAL/OP_JALR -> program_counter+4 (mod 2^WIDTH); OP_ARITHMETIC, OP_ARITHMETIC_IMMEDIATE, OP_AUIPC, OP_LUI -> alu_result; OP_STORE, OP_BRANCH, unknown -> write_flag=0.
REQ-017 Load format: shift load_data right by 8*byte_offset; funct3 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend byte, 101 zero-extend half; other funct3 -> write_flag=0.
REQ-018 Misaligned: half with byte_offset=3, or word with byte_offset!=0 -> write_flag=0, misaligned_load pulses 1 cycle on accept; instruction still counts as retired.
REQ-019 rd=0 -> write_flag=0 (x0 never written).
REQ-020 regport_write.enable = hold_valid && write_flag; address/data from holding register.
REQ-021 Holding register clears when write completes (enable && regport_write_ready) or write_flag=0, unless a new accept refills it the same cycle.
REQ-022 enable held with stable address/data while regport_write_ready=0; tready=0 during the stall.
REQ-023 fwd_valid = hold_valid && write_flag; fwd_rd, fwd_data mirror holding register.
REQ-024 instret increments by 1 per accepted instruction, wraps at 2^64.
REQ-025 Back-to-back accepts sustain one retire per cycle when regport_write_ready=1.

Reset
REQ-026 rst low: hold_valid=0, write_flag=0, instret=0, misaligned_load=0, regport_write.enable=0, fwd_valid=0; axis_in.tready=1 after rst deassertion.
REQ-027 Reset mid-stall discards the pending write; no write asserted in the first cycle after release.

Verification
REQ-028 LOAD funct3=000, load_data=0x0000_80FF, byte_offset=1, rd=5 -> next cycle enable=1, address=5, data=0xFFFF_FF80; instret=1.
REQ-029 JAL, pc=0x0000_0100, rd=1 -> data=0x0000_0104; rd=0 variant -> enable never asserts, instret still increments.
REQ-030 LOAD funct3=010, byte_offset=2 -> misaligned_load pulses 1 cycle, no write.
REQ-031 ADD alu_result=0x1234 with regport_write_ready=0 for 3 cycles -> enable held 4 cycles, data stable, tready=0 for 3 cycles, then single write.
REQ-032 Four back-to-back OP_ARITHMETIC, ready=1 -> four writes on consecutive cycles, fwd_rd tracks each, instret=4.
REQ-033 Assert rst during stall -> enable=0, instret=0 immediately (asynchronous), no write after release.

Source files
------------

// File: rtl/stage5_writeback.sv
// Writeback stage: formats retiring results into one holding register that drives the register-file write port.
// Latency 1 from accept to write; tready drops only while a pending write waits on regport_write_ready.
module stage5_writeback #(
  parameter  int WIDTH          = 32,
  parameter  int REGISTER_DEPTH = 32,
  localparam int AW             = $clog2(REGISTER_DEPTH),
  localparam int TDATA_W        = 3 * WIDTH + 7 + AW + 3 + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axis_in_tvalid,
  output logic               axis_in_tready,
  input  logic [TDATA_W-1:0] axis_in_tdata,
  output logic               regport_write_enable,
  output logic [AW-1:0]      regport_write_address,
  output logic [WIDTH-1:0]   regport_write_data,
  input  logic               regport_write_ready,
  output logic               fwd_valid,
  output logic [AW-1:0]      fwd_rd,
  output logic [WIDTH-1:0]   fwd_data,
  output logic               misaligned_load,
  output logic [63:0]        instret
);

  localparam logic [6:0] OP_LOAD                 = 7'b0000011;
  localparam logic [6:0] OP_STORE                = 7'b0100011;
  localparam logic [6:0] OP_BRANCH               = 7'b1100011;
  localparam logic [6:0] OP_JAL                  = 7'b1101111;
  localparam logic [6:0] OP_JALR                 = 7'b1100111;
  localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
  localparam logic [6:0] OP_AUIPC                = 7'b0010111;
  localparam logic [6:0] OP_LUI                  = 7'b0110111;

  typedef struct packed {
    logic [WIDTH-1:0] program_counter;
    logic [6:0]       opcode;
    logic [AW-1:0]    rd;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] load_data;
    logic [1:0]       byte_offset;
  } tdata_t;

  tdata_t           in_s;
  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;
  logic             load_ok;
  logic             load_misaligned;
  logic [WIDTH-1:0] result;
  logic             result_ok;
  logic             is_misaligned;
  logic             new_write_flag;

  logic             hold_valid_q, hold_valid_d;
  logic             write_flag_q, write_flag_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             misaligned_q, misaligned_d;
  logic [63:0]      instret_q, instret_d;

  assign in_s   = tdata_t'(axis_in_tdata);
  assign accept = axis_in_tvalid && axis_in_tready;

  always_comb begin
    shifted         = in_s.load_data >> {in_s.byte_offset, 3'b000};
    load_val        = '0;
    load_ok         = 1'b1;
    load_misaligned = 1'b0;
    case (in_s.funct3)
      3'b000: load_val = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001: begin
        load_val        = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
        load_misaligned = (in_s.byte_offset == 2'd3);
      end
      3'b010: begin
        load_val        = shifted;
        load_misaligned = (in_s.byte_offset != 2'd0);
      end
      3'b100: load_val = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101: begin
        load_val        = {{(WIDTH-16){1'b0}}, shifted[15:0]};
        load_misaligned = (in_s.byte_offset == 2'd3);
      end
      default: load_ok = 1'b0;
    endcase
  end

  always_comb begin
    result        = in_s.alu_result;
    result_ok     = 1'b0;
    is_misaligned = 1'b0;
    case (in_s.opcode)
      OP_LOAD: begin
        result        = load_val;
        result_ok     = load_ok;
        is_misaligned = load_misaligned;
      end
      OP_JAL, OP_JALR: begin
        result    = in_s.program_counter + WIDTH'(4);
        result_ok = 1'b1;
      end
      OP_ARITHMETIC, OP_ARITHMETIC_IMMEDIATE, OP_AUIPC, OP_LUI: result_ok = 1'b1;
      OP_STORE, OP_BRANCH: result_ok = 1'b0;
      default: result_ok = 1'b0;
    endcase
    new_write_flag = result_ok && !is_misaligned && (in_s.rd != '0);
  end

  // Stage drains when its write lands or when it carries no write at all.
  assign axis_in_tready = !hold_valid_q || regport_write_ready || !write_flag_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    write_flag_d = write_flag_q;
    rd_d         = rd_q;
    data_d       = data_q;
    misaligned_d = accept && is_misaligned;
    instret_d    = instret_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      write_flag_d = new_write_flag;
      rd_d         = in_s.rd;
      data_d       = result;
      instret_d    = instret_q + 64'd1;
    end else if (hold_valid_q && (regport_write_ready || !write_flag_q)) begin
      hold_valid_d = 1'b0;
      write_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      write_flag_q <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      misaligned_q <= 1'b0;
      instret_q    <= 64'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      write_flag_q <= write_flag_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
    end
  end

  assign regport_write_enable  = hold_valid_q && write_flag_q;
  assign regport_write_address = rd_q;
  assign regport_write_data    = data_q;
  assign fwd_valid             = hold_valid_q && write_flag_q;
  assign fwd_rd                = rd_q;
  assign fwd_data              = data_q;
  assign misaligned_load       = misaligned_q;
  assign instret               = instret_q;

endmodule

// File: tb/tb_stage5_writeback.sv
// Directed bench for stage5_writeback: expected writes are queued at issue and a negedge monitor retires them.
module tb_stage5_writeback;

  typedef struct packed {
    logic [31:0] program_counter;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [1:0]  byte_offset;
  } tdata_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] ARITH = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        tvalid;
  logic        tready;
  tdata_t      tdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        mis;
  logic [63:0] instret;

  int    checks = 0;
  int    failures = 0;
  int    wr_cnt = 0;
  int    mis_seen = 0;
  int    mis_exp = 0;
  wr_t   exp_q[$];

  stage5_writeback #(.WIDTH(32), .REGISTER_DEPTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .axis_in_tvalid        (tvalid),
    .axis_in_tready        (tready),
    .axis_in_tdata         (tdata),
    .regport_write_enable  (wr_en),
    .regport_write_address (wr_addr),
    .regport_write_data    (wr_data),
    .regport_write_ready   (wr_rdy),
    .fwd_valid             (fwd_valid),
    .fwd_rd                (fwd_rd),
    .fwd_data              (fwd_data),
    .misaligned_load       (mis),
    .instret               (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic tdata_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                                input logic [1:0] off);
    tdata_t t;
    t.program_counter = pc;
    t.opcode          = op;
    t.rd              = rd;
    t.funct3          = f3;
    t.alu_result      = alu;
    t.load_data       = ld;
    t.byte_offset     = off;
    return t;
  endfunction

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input tdata_t t);
    int n;
    tvalid = 1'b1;
    tdata  = t;
    n = 0;
    @(negedge clk);
    while (!tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!tready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
        check("fwd_rd", {59'd0, fwd_rd}, {59'd0, wr_addr});
      end
      if (wr_en && wr_rdy) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, wr_addr, wr_data}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
          check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
        end
      end
      if (mis) mis_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst    = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    wr_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_en", {63'd0, wr_en}, 64'd0);
    check("rst_fwd", {63'd0, fwd_valid}, 64'd0);
    check("rst_mis", {63'd0, mis}, 64'd0);
    check("rst_instret", instret, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("tready_after_rst", {63'd0, tready}, 64'd1);
    @(posedge clk);
    #1;

    // Sign-extended byte load at offset 1.
    push(5'd5, 32'hFFFF_FF80);
    send(mk(32'h0, LOAD, 5'd5, 3'b000, 32'h0, 32'h0000_80FF, 2'd1));
    @(negedge clk);
    check("instret_1", instret, 64'd1);
    check("en_after_load", {63'd0, wr_en}, 64'd1);
    @(posedge clk); #1;

    push(5'd1, 32'h0000_0104);
    send(mk(32'h0000_0100, JAL, 5'd1, 3'b000, 32'h0, 32'h0, 2'd0));
    send(mk(32'h0000_0100, JAL, 5'd0, 3'b000, 32'h0, 32'h0, 2'd0));
    @(negedge clk);
    check("instret_rd0", instret, 64'd3);
    check("en_rd0", {63'd0, wr_en}, 64'd0);
    @(posedge clk); #1;

    // Other load formats on 0xABCD1234.
    push(5'd2, 32'h0000_ABCD);
    send(mk(32'h0, LOAD, 5'd2, 3'b101, 32'h0, 32'hABCD_1234, 2'd2));
    push(5'd3, 32'hFFFF_ABCD);
    send(mk(32'h0, LOAD, 5'd3, 3'b001, 32'h0, 32'hABCD_1234, 2'd2));
    push(5'd4, 32'h0000_00AB);
    send(mk(32'h0, LOAD, 5'd4, 3'b100, 32'h0, 32'hABCD_1234, 2'd3));
    send(mk(32'h0, LOAD, 5'd6, 3'b011, 32'h0, 32'hABCD_1234, 2'd0));
    send(mk(32'h0, STORE, 5'd6, 3'b010, 32'h55, 32'h0, 2'd0));

    // Misaligned word load: pulse only, no write.
    mis_exp++;
    send(mk(32'h0, LOAD, 5'd7, 3'b010, 32'h0, 32'h1111_2222, 2'd2));
    @(negedge clk);
    check("mis_pulse", {63'd0, mis}, 64'd1);
    check("mis_no_write", {63'd0, wr_en}, 64'd0);
    @(negedge clk);
    check("mis_pulse_end", {63'd0, mis}, 64'd0);
    mis_exp++;
    @(posedge clk); #1;
    send(mk(32'h0, LOAD, 5'd8, 3'b001, 32'h0, 32'h1111_2222, 2'd3));
    @(negedge clk);
    check("instret_mis", instret, 64'd10);
    @(posedge clk); #1;

    // Write stall for three cycles.
    wr_rdy = 1'b0;
    push(5'd10, 32'h0000_1234);
    send(mk(32'h0, ARITH, 5'd10, 3'b000, 32'h0000_1234, 32'h0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_en", {63'd0, wr_en}, 64'd1);
      check("stall_data", {32'd0, wr_data}, 64'h1234);
      check("stall_tready", {63'd0, tready}, 64'd0);
    end
    @(posedge clk);
    #1 wr_rdy = 1'b1;
    @(negedge clk);
    check("stall_release_en", {63'd0, wr_en}, 64'd1);
    @(negedge clk);
    check("stall_done_en", {63'd0, wr_en}, 64'd0);
    @(posedge clk); #1;

    // Four back-to-back arithmetic results.
    base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      push(5'(11 + i), 32'hA000_0000 + 32'(i));
      send(mk(32'h0, ARITH, 5'(11 + i), 3'b000, 32'hA000_0000 + 32'(i), 32'h0, 2'd0));
    end
    @(negedge clk);
    check("b2b_instret", instret, 64'd15);
    @(negedge clk);
    #1 check("b2b_writes", 64'(wr_cnt - base), 64'd4);
    @(posedge clk); #1;

    // Reset asserted while a write is stalled.
    wr_rdy = 1'b0;
    send(mk(32'h0, ARITH, 5'd9, 3'b000, 32'hDEAD_BEEF, 32'h0, 2'd0));
    @(negedge clk);
    check("pre_rst_en", {63'd0, wr_en}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_en", {63'd0, wr_en}, 64'd0);
    check("async_rst_instret", instret, 64'd0);
    check("async_rst_fwd", {63'd0, fwd_valid}, 64'd0);
    @(posedge clk);
    #1 wr_rdy = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_en", {63'd0, wr_en}, 64'd0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("mis_count", 64'(mis_seen), 64'(mis_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
